// File: rtl/mdio_transmitter.sv
// ============================================================================
// mdio_transmitter
// ----------------------------------------------------------------------------
// Station (management) side of a Clause-22 MDIO link. A 32-bit frame latched
// on MDIO_START is shifted out MSB first on MDIO_OUT, one bit per rising MDC
// edge. Write frames drive all 32 bits. Read frames drive the 14 header bits,
// release the line for the two turnaround bits and the sixteen data bits, and
// shift the PHY's reply in from MDIO_IN.
//
// Optional build macro:
//   MDIO_PREAMBLE_EN - when defined, 32 ones (line driven) precede every
//                      frame. When undefined, the frame starts immediately.
//
// Ports:
//   MDC        in   1   management clock, all state changes on rising edge
//   reset      in   1   synchronous active-high reset
//   MDIO_START in   1   one-cycle request, only honoured while idle
//   T_DATA     in  32   frame {ST, OP, PHYAD, REGAD, TA, DATA}
//   MDIO_IN    in   1   serial data from the PHY during the read data phase
//   MDIO_OUT   out  1   registered serial frame bit
//   MDIO_OE    out  1   1 = block drives the line, 0 = line released
//   MDIO_DONE  out  1   one-cycle completion pulse
//   RD_DATA    out 16   last captured read word
//   BUSY       out  1   high from first driven bit through the DONE cycle
// ============================================================================
module mdio_transmitter (
    input  logic        MDC,
    input  logic        reset,
    input  logic        MDIO_START,
    input  logic [31:0] T_DATA,
    input  logic        MDIO_IN,
    output logic        MDIO_OUT,
    output logic        MDIO_OE,
    output logic        MDIO_DONE,
    output logic [15:0] RD_DATA,
    output logic        BUSY
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
`ifdef MDIO_PREAMBLE_EN
        ST_PREAMBLE = 3'd1,
`endif
        ST_SEND     = 3'd2,
        ST_RECV     = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    // Only OP == 2'b10 is a read; every other opcode is sent as a write.
    function automatic logic op_is_read(input logic [1:0] op);
        op_is_read = (op == 2'b10);
    endfunction

    state_t      r_state;
    logic [4:0]  r_bit_cnt;
    logic [31:0] r_frame;
    logic        r_is_read;
    // Holds data bits 15..1; bit 0 is taken straight from MDIO_IN on the
    // edge that also raises MDIO_DONE, so the word is valid in that cycle.
    logic [14:0] r_shift;
    logic        r_mdio_out;
    logic        r_mdio_oe;
    logic        r_mdio_done;
    logic [15:0] r_rd_data;
    logic        r_busy;

    assign MDIO_OUT  = r_mdio_out;
    assign MDIO_OE   = r_mdio_oe;
    assign MDIO_DONE = r_mdio_done;
    assign RD_DATA   = r_rd_data;
    assign BUSY      = r_busy;

    // Frame sequencer: state, bit counter, frame latch and registered outputs.
    always_ff @(posedge MDC) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_bit_cnt   <= 5'd0;
            r_frame     <= 32'h0000_0000;
            r_is_read   <= 1'b0;
            r_shift     <= 15'h0000;
            r_mdio_out  <= 1'b0;
            r_mdio_oe   <= 1'b0;
            r_mdio_done <= 1'b0;
            r_rd_data   <= 16'h0000;
            r_busy      <= 1'b0;
        end else begin
            r_mdio_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_mdio_out <= 1'b0;
                    r_mdio_oe  <= 1'b0;
                    r_busy     <= 1'b0;
                    if (MDIO_START) begin
                        r_frame   <= T_DATA;
                        r_is_read <= op_is_read(T_DATA[29:28]);
                        r_bit_cnt <= 5'd31;
`ifdef MDIO_PREAMBLE_EN
                        r_state   <= ST_PREAMBLE;
`else
                        r_state   <= ST_SEND;
`endif
                    end else begin
                        r_state   <= ST_IDLE;
                    end
                end

`ifdef MDIO_PREAMBLE_EN
                ST_PREAMBLE: begin
                    r_mdio_out <= 1'b1;
                    r_mdio_oe  <= 1'b1;
                    r_busy     <= 1'b1;
                    if (r_bit_cnt == 5'd0) begin
                        r_bit_cnt <= 5'd31;
                        r_state   <= ST_SEND;
                    end else begin
                        r_bit_cnt <= r_bit_cnt - 5'd1;
                        r_state   <= ST_PREAMBLE;
                    end
                end
`endif

                ST_SEND: begin
                    r_mdio_out <= r_frame[r_bit_cnt];
                    r_mdio_oe  <= 1'b1;
                    r_busy     <= 1'b1;
                    if (r_is_read && (r_bit_cnt == 5'd18)) begin
                        // Last header bit (REGAD LSB) goes out now; release
                        // the line from the turnaround onward.
                        r_bit_cnt <= 5'd17;
                        r_state   <= ST_RECV;
                    end else if (r_bit_cnt == 5'd0) begin
                        r_bit_cnt <= 5'd0;
                        r_state   <= ST_DONE;
                    end else begin
                        r_bit_cnt <= r_bit_cnt - 5'd1;
                        r_state   <= ST_SEND;
                    end
                end

                ST_RECV: begin
                    r_mdio_out <= 1'b0;
                    r_mdio_oe  <= 1'b0;
                    r_busy     <= 1'b1;
                    // The edge that starts bit period c ends period c+1, so
                    // data bits 15..1 are sampled while the count is 14..0.
                    if (r_bit_cnt <= 5'd14) begin
                        r_shift <= {r_shift[13:0], MDIO_IN};
                    end else begin
                        r_shift <= r_shift;
                    end
                    if (r_bit_cnt == 5'd0) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_bit_cnt <= r_bit_cnt - 5'd1;
                        r_state   <= ST_RECV;
                    end
                end

                ST_DONE: begin
                    r_mdio_out  <= 1'b0;
                    r_mdio_oe   <= 1'b0;
                    r_mdio_done <= 1'b1;
                    r_busy      <= 1'b1;
                    // This edge ends data bit 0 of a read.
                    if (r_is_read) begin
                        r_rd_data <= {r_shift, MDIO_IN};
                    end else begin
                        r_rd_data <= r_rd_data;
                    end
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_mdio_out <= 1'b0;
                    r_mdio_oe  <= 1'b0;
                    r_busy     <= 1'b0;
                    r_bit_cnt  <= 5'd0;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdio_transmitter.sv
// Directed bench for mdio_transmitter: write, read, busy rejection, reset
// mid-frame and back-to-back frames, with optional preamble timing.
module tb_mdio_transmitter;

    logic        MDC = 1'b0;
    logic        reset = 1'b1;
    logic        MDIO_START = 1'b0;
    logic [31:0] T_DATA = 32'h0000_0000;
    logic        MDIO_IN = 1'b0;
    logic        MDIO_OUT;
    logic        MDIO_OE;
    logic        MDIO_DONE;
    logic [15:0] RD_DATA;
    logic        BUSY;

`ifdef MDIO_PREAMBLE_EN
    localparam int PRE = 32;
`else
    localparam int PRE = 0;
`endif

    int n_pass  = 0;
    int n_total = 0;

    mdio_transmitter dut (
        .MDC        (MDC),
        .reset      (reset),
        .MDIO_START (MDIO_START),
        .T_DATA     (T_DATA),
        .MDIO_IN    (MDIO_IN),
        .MDIO_OUT   (MDIO_OUT),
        .MDIO_OE    (MDIO_OE),
        .MDIO_DONE  (MDIO_DONE),
        .RD_DATA    (RD_DATA),
        .BUSY       (BUSY)
    );

    always #5 MDC = ~MDC;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge MDC);
        #1;
    endtask

    // Present a one-cycle start; on return we sit in cycle N (after edge N).
    task automatic start_frame(input logic [31:0] d);
        T_DATA     = d;
        MDIO_START = 1'b1;
        tick();
        MDIO_START = 1'b0;
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        MDIO_START = 1'b1;
        T_DATA     = 32'h5A3C_BEEF;
        tick();
        tick();
        n_total++; if (MDIO_OUT !== 1'b0) $display("FAIL reset_out: got %b expected 0", MDIO_OUT); else n_pass++;
        n_total++; if (MDIO_OE !== 1'b0) $display("FAIL reset_oe: got %b expected 0", MDIO_OE); else n_pass++;
        n_total++; if (MDIO_DONE !== 1'b0) $display("FAIL reset_done: got %b expected 0", MDIO_DONE); else n_pass++;
        n_total++; if (RD_DATA !== 16'h0000) $display("FAIL reset_rd: got %h expected 0000", RD_DATA); else n_pass++;
        n_total++; if (BUSY !== 1'b0) $display("FAIL reset_busy: got %b expected 0", BUSY); else n_pass++;
        MDIO_START = 1'b0;
        reset      = 1'b0;
        tick();
        n_total++; if ({MDIO_OE, BUSY} !== 2'b00) $display("FAIL reset_start_ignored: got oe,busy=%b expected 00", {MDIO_OE, BUSY}); else n_pass++;
    endtask

    task automatic test_write();
        logic [31:0] d;
        d = 32'h5A3C_BEEF;
        start_frame(d);
        for (int k = 0; k < PRE; k++) begin
            tick();
            n_total++; if ({MDIO_OUT, MDIO_OE} !== 2'b11) $display("FAIL wr_preamble[%0d]: got out,oe=%b expected 11", k, {MDIO_OUT, MDIO_OE}); else n_pass++;
        end
        for (int i = 31; i >= 0; i--) begin
            tick();
            n_total++;
            if ({MDIO_OUT, MDIO_OE, BUSY, MDIO_DONE} !== {d[i], 1'b1, 1'b1, 1'b0})
                $display("FAIL wr_bit[%0d]: got out,oe,busy,done=%b expected %b", i, {MDIO_OUT, MDIO_OE, BUSY, MDIO_DONE}, {d[i], 3'b110});
            else n_pass++;
        end
        tick();
        n_total++; if (MDIO_DONE !== 1'b1) $display("FAIL wr_done: got %b expected 1", MDIO_DONE); else n_pass++;
        n_total++; if (MDIO_OE !== 1'b0) $display("FAIL wr_done_oe: got %b expected 0", MDIO_OE); else n_pass++;
        n_total++; if (BUSY !== 1'b1) $display("FAIL wr_done_busy: got %b expected 1", BUSY); else n_pass++;
        n_total++; if (RD_DATA !== 16'h0000) $display("FAIL wr_rd_unchanged: got %h expected 0000", RD_DATA); else n_pass++;
        tick();
        n_total++; if ({MDIO_DONE, BUSY} !== 2'b00) $display("FAIL wr_idle: got done,busy=%b expected 00", {MDIO_DONE, BUSY}); else n_pass++;
    endtask

    task automatic test_read();
        logic [31:0] d;
        logic [15:0] rdw;
        d   = 32'h6842_0000;
        rdw = 16'hA5C3;
        start_frame(d);
        for (int k = 0; k < PRE; k++) begin
            tick();
            n_total++; if ({MDIO_OUT, MDIO_OE} !== 2'b11) $display("FAIL rd_preamble[%0d]: got out,oe=%b expected 11", k, {MDIO_OUT, MDIO_OE}); else n_pass++;
        end
        for (int k = 0; k < 14; k++) begin
            tick();
            n_total++; if ({MDIO_OUT, MDIO_OE} !== {d[31-k], 1'b1}) $display("FAIL rd_hdr[%0d]: got out,oe=%b expected %b", k, {MDIO_OUT, MDIO_OE}, {d[31-k], 1'b1}); else n_pass++;
        end
        for (int j = 0; j < 18; j++) begin
            tick();
            n_total++; if ({MDIO_OUT, MDIO_OE, MDIO_DONE} !== 3'b000) $display("FAIL rd_release[%0d]: got out,oe,done=%b expected 000", j, {MDIO_OUT, MDIO_OE, MDIO_DONE}); else n_pass++;
            if (j == 17) begin
                n_total++; if (RD_DATA !== 16'h0000) $display("FAIL rd_early: got %h expected 0000", RD_DATA); else n_pass++;
            end
            if (j >= 2) MDIO_IN = rdw[17-j];
        end
        tick();
        MDIO_IN = 1'b0;
        n_total++; if (MDIO_DONE !== 1'b1) $display("FAIL rd_done: got %b expected 1", MDIO_DONE); else n_pass++;
        n_total++; if (RD_DATA !== 16'hA5C3) $display("FAIL rd_data: got %h expected a5c3", RD_DATA); else n_pass++;
        n_total++; if ({MDIO_OE, BUSY} !== 2'b01) $display("FAIL rd_done_oe_busy: got %b expected 01", {MDIO_OE, BUSY}); else n_pass++;
        tick();
        n_total++; if ({MDIO_DONE, BUSY} !== 2'b00) $display("FAIL rd_idle: got done,busy=%b expected 00", {MDIO_DONE, BUSY}); else n_pass++;
        n_total++; if (RD_DATA !== 16'hA5C3) $display("FAIL rd_hold: got %h expected a5c3", RD_DATA); else n_pass++;
    endtask

    task automatic test_busy();
        logic [31:0] a;
        logic [31:0] b;
        int dones;
        a     = 32'h5123_4567;
        b     = 32'h6FFF_FFFF;
        dones = 0;
        start_frame(a);
        for (int k = 1; k <= PRE + 40; k++) begin
            tick();
            if (MDIO_DONE === 1'b1) dones++;
            if (k > PRE && k <= PRE + 32) begin
                n_total++; if ({MDIO_OUT, MDIO_OE} !== {a[PRE+32-k], 1'b1}) $display("FAIL busy_frame[%0d]: got out,oe=%b expected %b", k, {MDIO_OUT, MDIO_OE}, {a[PRE+32-k], 1'b1}); else n_pass++;
            end
            if (k >= PRE + 34) begin
                n_total++; if ({MDIO_OE, BUSY} !== 2'b00) $display("FAIL busy_done_start_ignored[%0d]: got oe,busy=%b expected 00", k, {MDIO_OE, BUSY}); else n_pass++;
            end
            if (k == 9) begin
                T_DATA     = b;
                MDIO_START = 1'b1;
            end else if (k == 10) begin
                MDIO_START = 1'b0;
            end else if (k == PRE + 32) begin
                MDIO_START = 1'b1;
            end else if (k == PRE + 33) begin
                MDIO_START = 1'b0;
            end
        end
        n_total++; if (dones !== 1) $display("FAIL busy_done_count: got %0d expected 1", dones); else n_pass++;
        n_total++; if (RD_DATA !== 16'hA5C3) $display("FAIL busy_rd_kept: got %h expected a5c3", RD_DATA); else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        logic [31:0] w;
        int dones;
        d     = 32'h6842_0000;
        w     = 32'h5ACE_1234;
        dones = 0;
        MDIO_IN = 1'b1;
        start_frame(d);
        for (int k = 1; k <= 20; k++) tick();
        reset = 1'b1;
        tick();
        n_total++; if (MDIO_OE !== 1'b0) $display("FAIL rst_mid_oe: got %b expected 0", MDIO_OE); else n_pass++;
        n_total++; if (BUSY !== 1'b0) $display("FAIL rst_mid_busy: got %b expected 0", BUSY); else n_pass++;
        n_total++; if (RD_DATA !== 16'h0000) $display("FAIL rst_mid_rd: got %h expected 0000", RD_DATA); else n_pass++;
        n_total++; if ({MDIO_OUT, MDIO_DONE} !== 2'b00) $display("FAIL rst_mid_out_done: got %b expected 00", {MDIO_OUT, MDIO_DONE}); else n_pass++;
        reset   = 1'b0;
        MDIO_IN = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (MDIO_DONE === 1'b1) dones++;
        end
        n_total++; if (dones !== 0) $display("FAIL rst_mid_no_done: got %0d expected 0", dones); else n_pass++;
        start_frame(w);
        for (int k = 0; k < PRE; k++) tick();
        for (int i = 31; i >= 0; i--) begin
            tick();
            n_total++; if ({MDIO_OUT, MDIO_OE} !== {w[i], 1'b1}) $display("FAIL rst_after_wr[%0d]: got out,oe=%b expected %b", i, {MDIO_OUT, MDIO_OE}, {w[i], 1'b1}); else n_pass++;
        end
        tick();
        n_total++; if (MDIO_DONE !== 1'b1) $display("FAIL rst_after_done: got %b expected 1", MDIO_DONE); else n_pass++;
        n_total++; if (RD_DATA !== 16'h0000) $display("FAIL rst_after_rd: got %h expected 0000", RD_DATA); else n_pass++;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        logic [31:0] b;
        a = 32'h5155_AAAA;
        b = 32'h5000_FFFF;
        start_frame(a);
        for (int k = 0; k < PRE; k++) tick();
        for (int i = 31; i >= 0; i--) begin
            tick();
            n_total++; if ({MDIO_OUT, MDIO_OE} !== {a[i], 1'b1}) $display("FAIL b2b_a[%0d]: got out,oe=%b expected %b", i, {MDIO_OUT, MDIO_OE}, {a[i], 1'b1}); else n_pass++;
        end
        tick();
        n_total++; if (MDIO_DONE !== 1'b1) $display("FAIL b2b_a_done: got %b expected 1", MDIO_DONE); else n_pass++;
        T_DATA     = b;
        MDIO_START = 1'b1;
        tick();
        MDIO_START = 1'b0;
        n_total++; if ({MDIO_OE, BUSY, MDIO_DONE} !== 3'b000) $display("FAIL b2b_gap: got oe,busy,done=%b expected 000", {MDIO_OE, BUSY, MDIO_DONE}); else n_pass++;
        for (int k = 0; k < PRE; k++) tick();
        for (int i = 31; i >= 0; i--) begin
            tick();
            n_total++; if ({MDIO_OUT, MDIO_OE} !== {b[i], 1'b1}) $display("FAIL b2b_b[%0d]: got out,oe=%b expected %b", i, {MDIO_OUT, MDIO_OE}, {b[i], 1'b1}); else n_pass++;
        end
        tick();
        n_total++; if (MDIO_DONE !== 1'b1) $display("FAIL b2b_b_done: got %b expected 1", MDIO_DONE); else n_pass++;
        tick();
    endtask

`ifdef MDIO_PREAMBLE_EN
    task automatic test_preamble();
        int cyc;
        cyc = 0;
        start_frame(32'h5A3C_BEEF);
        while (cyc < 80) begin
            tick();
            cyc++;
            if (MDIO_DONE === 1'b1) break;
        end
        n_total++; if (cyc !== 65) $display("FAIL pre_done_cycle: got N+%0d expected N+65", cyc); else n_pass++;
        tick();
    endtask
`endif

    initial begin
        tick();
        test_reset();
        test_write();
        test_read();
        test_busy();
        test_reset_mid();
        test_back_to_back();
`ifdef MDIO_PREAMBLE_EN
        test_preamble();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mdio_transmitter.md
# mdio_transmitter

- Management-side (station) end of the MDIO link; feeds the PHY-side receiver over MDIO_OUT/MDIO_OE.
- Serializes a 32-bit Clause-22 frame MSB first, clocked by the shared MDC.
- For write frames it drives all 32 bits.
- For read frames it drives the 14 header bits, releases the line for turnaround plus 16 data bits, captures the returned word from MDIO_IN, and signals completion.

## Interface
Parameters: none.

Ports:
- MDC  input  1  management clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- MDIO_START  input  1  one-cycle request; sampled only in IDLE.
- T_DATA  input  32  frame to send:
  - [31:30] ST
  - [29:28] OP (01 write, 10 read)
  - [27:23] PHYAD
  - [22:18] REGAD
  - [17:16] TA
  - [15:0] data
- MDIO_IN  input  1  serial data returned by the PHY during read data phase.
- MDIO_OUT  output  1  serial frame bit, registered.
- MDIO_OE  output  1  1 = block drives MDIO_OUT; 0 = line released.
- MDIO_DONE  output  1  one-cycle completion pulse.
- RD_DATA  output  16  last captured read word.
- BUSY  output  1  high from start acceptance until the MDIO_DONE cycle, inclusive.

## Operation
- States: IDLE, PREAMBLE, SEND, RECV, DONE. 5-bit down counter `bit_cnt`. 32-bit frame latch `frame`.
- IDLE:
  - MDIO_OE=0, MDIO_OUT=0, BUSY=0.
  - On MDIO_START=1: latch T_DATA into `frame`, set `is_read = (T_DATA[29:28]==2'b10)`, and go to PREAMBLE (if the preamble is configured in) or SEND. Load bit_cnt=31.
- PREAMBLE: MDIO_OE=1, MDIO_OUT=1 for 32 cycles, then go to SEND with bit_cnt=31.
- SEND:
  - MDIO_OE=1, MDIO_OUT=frame[bit_cnt]; decrement each cycle.
  - Write (any OP other than 10): stay in SEND through bit 0, then go to DONE.
  - Read: after bit 18 is driven, go to RECV with bit_cnt=17.
- RECV:
  - MDIO_OE=0, MDIO_OUT=0.
  - Bits 17..16 (TA) are ignored.
  - For bits 15..0, MDIO_IN is sampled at the rising edge ending that bit period and shifted into an internal register MSB first.
  - After bit 0, the register is copied to RD_DATA and the FSM goes to DONE.
- DONE: MDIO_DONE=1 for one cycle, MDIO_OE=0, then go to IDLE.
- ST is not checked; the frame is sent as latched.
- RD_DATA changes only at completion of a read; write frames leave it unchanged.

## Timing
- Reset values: MDIO_OUT=0, MDIO_OE=0, MDIO_DONE=0, RD_DATA=16'h0000, BUSY=0, state=IDLE.
- Start acceptance:
  - MDIO_START high at edge N means the first driven bit (preamble or frame bit 31) is valid after edge N+1.
  - BUSY is high after edge N+1.
- Write latency (no preamble):
  - Bits 31..0 occupy cycles N+1..N+32.
  - MDIO_DONE is high in cycle N+33.
  - The block is back in IDLE at N+34. Earliest next accepted start is edge N+34.
- Read latency (no preamble):
  - OE=1 for 14 cycles.
  - OE=0 for 18 cycles.
  - MDIO_DONE is high in cycle N+33 with RD_DATA already valid.
- Preamble adds exactly 32 cycles to every figure above.
- MDIO_START while BUSY is ignored, with no queuing.
- MDIO_START on the DONE cycle is ignored.
- A T_DATA change after acceptance has no effect on the frame in flight.
- Reset asserted mid-frame:
  - All outputs take reset values at the next edge.
  - A partial read word is discarded and RD_DATA is cleared.
  - No MDIO_DONE pulse.
- Reset and MDIO_START together: reset wins.

## Configuration
- MDIO_PREAMBLE_EN defined: PREAMBLE state is present, and 32 ones are driven (OE=1) before every frame.
- MDIO_PREAMBLE_EN undefined:
  - PREAMBLE state and its logic are absent.
  - IDLE goes directly to SEND.
  - Latencies as in Timing without the preamble adder.

## Test plan
- Write, T_DATA=32'h5A3C_BEEF (ST 01, OP 01):
  - MDIO_OUT reproduces 0x5A3CBEEF MSB first over 32 cycles with OE=1.
  - MDIO_DONE pulses at N+33.
  - RD_DATA stays 0.
- Read, T_DATA=32'h6842_0000 (OP 10):
  - OE=1 for 14 cycles, then 0.
  - The bench drives 16'hA5C3 on MDIO_IN during the data phase.
  - RD_DATA=16'hA5C3 when MDIO_DONE pulses at N+33.
- Busy rejection:
  - Pulse MDIO_START again at N+10 with different T_DATA.
  - The transmitted frame is unchanged.
  - Exactly one MDIO_DONE.
- Reset at cycle 20 of a read:
  - Next edge gives OE=0, BUSY=0, RD_DATA=0.
  - No MDIO_DONE.
  - A following write completes normally.
- With MDIO_PREAMBLE_EN:
  - 32 ones precede the frame.
  - MDIO_DONE moves to N+65.
- Back-to-back transfers: start accepted at edge N+34 after a write; the second frame begins at N+35.
